// File: rtl/syscall_pkg.sv
// Shared service codes, FSM state encoding and the decimal power table for the syscall console.
package syscall_pkg;

  localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
  localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
  localparam logic [31:0] SYS_EXIT       = 32'd10;
  localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

  typedef enum logic [2:0] {
    IDLE,
    INT_DIGIT,
    STR_REQ,
    STR_WAIT,
    EMIT,
    DONE,
    HALTED
  } state_t;

  localparam logic [31:0] POW10 [10] = '{
    32'd1,
    32'd10,
    32'd100,
    32'd1000,
    32'd10000,
    32'd100000,
    32'd1000000,
    32'd10000000,
    32'd100000000,
    32'd1000000000
  };

endpackage

// File: rtl/dec_digit_gen.sv
// Repeated-subtraction decimal digit generator, most significant digit first, one compare per cycle.
// A finished digit is held on digit_valid until digit_ready; leading zeros are skipped internally.
module dec_digit_gen
  import syscall_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] magnitude,
  output logic        digit_valid,
  input  logic        digit_ready,
  output logic [3:0]  digit,
  output logic        digit_last
);

  logic        running;
  logic        emitted;
  logic [31:0] mag;
  logic [3:0]  k;
  logic [3:0]  digit_q;
  logic        ge;
  logic        show;

  assign ge          = (mag >= POW10[k]);
  // Zero digits are shown once a significant digit has gone out, or at the units place.
  assign show        = running && !ge && ((digit_q != 4'd0) || emitted || (k == 4'd0));
  assign digit_valid = show;
  assign digit       = digit_q;
  assign digit_last  = (k == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      running <= 1'b0;
      emitted <= 1'b0;
      mag     <= 32'd0;
      k       <= 4'd0;
      digit_q <= 4'd0;
    end else if (start) begin
      running <= 1'b1;
      emitted <= 1'b0;
      mag     <= magnitude;
      k       <= 4'd9;
      digit_q <= 4'd0;
    end else if (running) begin
      if (ge) begin
        mag     <= mag - POW10[k];
        digit_q <= digit_q + 4'd1;
      end else if (show) begin
        if (digit_ready) begin
          emitted <= 1'b1;
          digit_q <= 4'd0;
          if (k == 4'd0) begin
            running <= 1'b0;
          end else begin
            k <= k - 4'd1;
          end
        end
      end else begin
        digit_q <= 4'd0;
        k       <= k - 4'd1;
      end
    end
  end

endmodule

// File: rtl/syscall_console.sv
// Syscall service FSM: prints ints, strings and chars to a valid/ready byte stream, halts on exit.
// Stalls the pipeline for the whole service; memory reads and char output each wait on their handshake.
module syscall_console
  import syscall_pkg::*;
#(
  parameter int MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall_control,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        stat_control
);

  state_t      state;
  state_t      state_nx;
  state_t      ret;
  state_t      ret_nx;
  logic [31:0] ptr_nx;
  logic [31:0] count;
  logic [31:0] count_nx;
  logic [7:0]  byte_nx;

  logic        gen_start;
  logic        gen_valid;
  logic        gen_ready;
  logic        gen_last;
  logic [3:0]  gen_digit;
  logic [31:0] mag;

  // Negation as unsigned keeps -2^31 representable as 2^31.
  assign mag       = a0[31] ? (32'd0 - a0) : a0;
  assign gen_ready = (state == INT_DIGIT);

  assign stall = ((state == IDLE) && syscall_control) ||
                 ((state != IDLE) && (state != DONE));

  dec_digit_gen u_digits (
    .clk         (clk),
    .reset       (reset),
    .start       (gen_start),
    .magnitude   (mag),
    .digit_valid (gen_valid),
    .digit_ready (gen_ready),
    .digit       (gen_digit),
    .digit_last  (gen_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      ret          <= IDLE;
      mem_addr     <= 32'd0;
      count        <= 32'd0;
      char_data    <= 8'd0;
      char_valid   <= 1'b0;
      mem_req      <= 1'b0;
      stat_control <= 1'b0;
    end else begin
      state        <= state_nx;
      ret          <= ret_nx;
      mem_addr     <= ptr_nx;
      count        <= count_nx;
      char_data    <= byte_nx;
      char_valid   <= (state_nx == EMIT);
      mem_req      <= (state_nx == STR_REQ) || (state_nx == STR_WAIT);
      stat_control <= stat_control || (state_nx == HALTED);
    end
  end

  always_comb begin
    state_nx  = state;
    ret_nx    = ret;
    ptr_nx    = mem_addr;
    count_nx  = count;
    byte_nx   = char_data;
    gen_start = 1'b0;

    case (state)
      IDLE: begin
        if (syscall_control) begin
          case (v0)
            SYS_PRINT_INT: begin
              gen_start = 1'b1;
              if (a0[31]) begin
                state_nx = EMIT;
                byte_nx  = 8'h2D;
                ret_nx   = INT_DIGIT;
              end else begin
                state_nx = INT_DIGIT;
              end
            end
            SYS_PRINT_STR: begin
              ptr_nx   = a0;
              count_nx = 32'd0;
              state_nx = STR_REQ;
            end
            SYS_PRINT_CHAR: begin
              state_nx = EMIT;
              byte_nx  = a0[7:0];
              ret_nx   = DONE;
            end
            SYS_EXIT: state_nx = HALTED;
            default:  state_nx = DONE;
          endcase
        end
      end

      INT_DIGIT: begin
        if (gen_valid) begin
          state_nx = EMIT;
          byte_nx  = 8'h30 + {4'd0, gen_digit};
          ret_nx   = gen_last ? DONE : INT_DIGIT;
        end
      end

      STR_REQ: state_nx = STR_WAIT;

      STR_WAIT: begin
        if (mem_ack) begin
          // The byte at the length limit is still fetched, then dropped.
          if ((mem_rdata == 8'd0) || (count == 32'(MAX_STR_LEN))) begin
            state_nx = DONE;
          end else begin
            state_nx = EMIT;
            byte_nx  = mem_rdata;
            ret_nx   = STR_REQ;
            ptr_nx   = mem_addr + 32'd1;
            count_nx = count + 32'd1;
          end
        end
      end

      EMIT: begin
        if (char_ready) begin
          state_nx = ret;
        end
      end

      DONE:    state_nx = IDLE;
      HALTED:  state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_syscall_console.sv
// Randomized scoreboard bench for syscall_console: a reference model queues expected bytes and read addresses.
module tb_syscall_console;

  localparam int MAX = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic        syscall_control;
  logic [31:0] v0;
  logic [31:0] a0;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [7:0]  char_data;
  logic        char_valid;
  logic        char_ready;
  logic        stat_control;

  always #5 clk = ~clk;

  syscall_console #(.MAX_STR_LEN(MAX)) dut (
    .clk             (clk),
    .reset           (reset),
    .syscall_control (syscall_control),
    .v0              (v0),
    .a0              (a0),
    .stall           (stall),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .char_data       (char_data),
    .char_valid      (char_valid),
    .char_ready      (char_ready),
    .stat_control    (stat_control)
  );

  logic [7:0]  mem [0:2047];
  byte unsigned exp_q[$];
  logic [31:0] exp_addr_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int hs_count = 0;
  int mem_hs = 0;
  int sink_mode = 0;
  logic [31:0] edges [10] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'd9, 32'd10, 32'd100,
                              32'd2147483647, 32'h80000000, 32'd1000000000, 32'd999999999};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Reference model: expected console bytes and memory read addresses for one request.
  task automatic expect_req(input logic [31:0] v, input logic [31:0] a);
    string s;
    logic [31:0] ad;
    case (v)
      32'd1: begin
        s = $sformatf("%0d", $signed(a));
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      end
      32'd4: begin
        for (int i = 0; i <= MAX; i++) begin
          ad = a + 32'(i);
          exp_addr_q.push_back(ad);
          if (mem[ad[10:0]] == 8'd0 || i == MAX) break;
          exp_q.push_back(mem[ad[10:0]]);
        end
      end
      32'd11: exp_q.push_back(a[7:0]);
      default: ;
    endcase
  endtask

  // Console sink and byte monitor.
  initial begin
    logic hold = 1'b0;
    logic [7:0] hold_dat = 8'd0;
    byte unsigned e;
    char_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
        char_ready = 1'b0;
      end else begin
        case (sink_mode)
          1: char_ready = 1'b0;
          2: char_ready = 1'b1;
          default: char_ready = ($urandom_range(0, 9) < 7);
        endcase
        if (hold) begin
          check("char_valid_held", {31'd0, char_valid}, 32'd1);
          check("char_data_held", {24'd0, char_data}, {24'd0, hold_dat});
        end
        if (char_valid && char_ready) begin
          hs_count++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_byte: got %02h, required none", char_data);
          end else begin
            e = exp_q.pop_front();
            check("char_byte", {24'd0, char_data}, {24'd0, e});
          end
        end
        hold = char_valid && !char_ready;
        hold_dat = char_data;
      end
    end
  end

  // Data memory responder: acks at the earliest in the cycle after the request is seen.
  initial begin
    int age = 0;
    int dly = 0;
    logic [31:0] ea;
    mem_ack = 1'b0;
    mem_rdata = 8'd0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        age = 0;
      end else if (mem_req) begin
        age++;
        if (age >= 2 + dly) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr[10:0]];
          mem_hs++;
          age = 0;
          dly = $urandom_range(0, 2);
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_mem_req: addr %08h, required none", mem_addr);
          end else begin
            ea = exp_addr_q.pop_front();
            check("mem_addr", mem_addr, ea);
          end
        end
      end else begin
        age = 0;
        if ($urandom_range(0, 9) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = 8'($urandom);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] v, input logic [31:0] a);
    @(negedge clk);
    syscall_control = 1'b1;
    v0 = v;
    a0 = a;
    expect_req(v, a);
    #1 check("stall_on_req", {31'd0, stall}, 32'd1);
  endtask

  task automatic finish_req(input string name, output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (stall && n < 5000);
    check({name, "_done"}, {31'd0, stall}, 32'd0);
    check({name, "_bytes_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_reads_drained"}, 32'(exp_addr_q.size()), 32'd0);
    syscall_control = 1'b0;
  endtask

  task automatic run_req(input string name, input logic [31:0] v, input logic [31:0] a);
    int n;
    issue(v, a);
    finish_req(name, n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int base;
    int mbase;
    int n;
    int sel;
    logic [31:0] v;
    logic [31:0] a;

    reset = 1'b1;
    syscall_control = 1'b0;
    v0 = 32'd0;
    a0 = 32'd0;
    for (int i = 0; i < 2048; i++) mem[i] = 8'd0;
    mem[11'h100] = 8'h48;
    mem[11'h101] = 8'h69;
    for (int i = 0; i < 300; i++) mem[11'h400 + 11'(i)] = 8'(8'h41 + 8'(i % 26));
    for (int i = 11'h600; i < 11'h7FF; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 255));

    #1;
    check("rst_char_valid", {31'd0, char_valid}, 32'd0);
    check("rst_char_data", {24'd0, char_data}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_stat", {31'd0, stat_control}, 32'd0);
    check("rst_stall_idle", {31'd0, stall}, 32'd0);
    syscall_control = 1'b1;
    v0 = 32'd1;
    #1 check("rst_stall_req", {31'd0, stall}, 32'd1);
    syscall_control = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    base = hs_count;
    run_req("int_zero", 32'd1, 32'd0);
    check("int_zero_count", 32'(hs_count - base), 32'd1);

    base = hs_count;
    run_req("int_min", 32'd1, 32'h80000000);
    check("int_min_count", 32'(hs_count - base), 32'd11);

    base = hs_count;
    mbase = mem_hs;
    run_req("str_hi", 32'd4, 32'h100);
    check("str_hi_count", 32'(hs_count - base), 32'd2);
    check("str_hi_reads", 32'(mem_hs - mbase), 32'd3);

    sink_mode = 1;
    base = hs_count;
    issue(32'd11, 32'h41);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("char_wait_valid", {31'd0, char_valid}, 32'd1);
      check("char_wait_data", {24'd0, char_data}, 32'h41);
      check("char_wait_stall", {31'd0, stall}, 32'd1);
    end
    sink_mode = 2;
    @(negedge clk);
    #1 check("char_accept_stall", {31'd0, stall}, 32'd1);
    finish_req("char_bp", n);
    check("char_done_latency", 32'(n), 32'd1);
    check("char_count", 32'(hs_count - base), 32'd1);
    sink_mode = 0;

    base = hs_count;
    mbase = mem_hs;
    run_req("str_trunc", 32'd4, 32'h400);
    check("str_trunc_count", 32'(hs_count - base), 32'd256);
    check("str_trunc_reads", 32'(mem_hs - mbase), 32'd257);

    for (int r = 0; r < 40; r++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4) begin
        v = 32'd1;
        a = ($urandom_range(0, 1) == 1) ? edges[$urandom_range(0, 9)] : $urandom;
      end else if (sel < 7) begin
        v = 32'd4;
        a = 32'h600 + 32'($urandom_range(0, 32'h1F0));
      end else if (sel < 9) begin
        v = 32'd11;
        a = $urandom;
      end else begin
        do v = $urandom; while (v == 32'd1 || v == 32'd4 || v == 32'd10 || v == 32'd11);
        a = $urandom;
      end
      run_req("rand", v, a);
    end

    base = hs_count;
    issue(32'd4, 32'h400);
    n = 0;
    while (hs_count < base + 50 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("midstr_progress", {31'd0, hs_count >= base + 50}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midrst_char_valid", {31'd0, char_valid}, 32'd0);
    check("midrst_char_data", {24'd0, char_data}, 32'd0);
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_mem_addr", mem_addr, 32'd0);
    check("midrst_stall_req", {31'd0, stall}, 32'd1);
    syscall_control = 1'b0;
    #1 check("midrst_stall_idle", {31'd0, stall}, 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    base = hs_count;
    mbase = mem_hs;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_bytes", 32'(hs_count - base), 32'd0);
    check("midrst_no_reads", 32'(mem_hs - mbase), 32'd0);

    base = hs_count;
    run_req("post_rst_char", 32'd11, 32'h37);
    check("post_rst_count", 32'(hs_count - base), 32'd1);

    base = hs_count;
    issue(32'd10, 32'd0);
    @(negedge clk);
    #1;
    check("halt_stat", {31'd0, stat_control}, 32'd1);
    check("halt_stall", {31'd0, stall}, 32'd1);
    syscall_control = 1'b0;
    #1 check("halt_stall_noreq", {31'd0, stall}, 32'd1);
    repeat (5) @(negedge clk);
    syscall_control = 1'b1;
    v0 = 32'd11;
    a0 = 32'h5A;
    repeat (20) @(negedge clk);
    #1;
    check("halt_no_bytes", 32'(hs_count - base), 32'd0);
    check("halt_stall_late", {31'd0, stall}, 32'd1);
    check("halt_char_valid", {31'd0, char_valid}, 32'd0);
    check("halt_stat_sticky", {31'd0, stat_control}, 32'd1);

    @(posedge clk);
    #2 reset = 1'b1;
    syscall_control = 1'b0;
    #1;
    check("final_rst_stat", {31'd0, stat_control}, 32'd0);
    check("final_rst_stall", {31'd0, stall}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base = hs_count;
    run_req("after_halt", 32'd1, 32'hFFFFFFF6);
    check("after_halt_count", 32'(hs_count - base), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/syscall_console.md
# syscall_console

Sequential syscall service unit that sits directly downstream of the pipeline's syscall decode point and drives the simulation console. It accepts a syscall request (`v0`, `a0`) and stalls the pipeline while it services the request:
- prints integers as decimal digits;
- prints null-terminated strings by reading data memory byte by byte;
- prints single characters;
- latches halt on exit.

Characters leave on a valid/ready byte stream toward the console sink.

## Interface
- `MAX_STR_LEN`, default 256: maximum bytes emitted per print-string; longer strings are truncated.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `syscall_control`  in  1  syscall instruction present; `v0`/`a0` are valid while high.
- `v0`  in  32  service code.
- `a0`  in  32  argument: integer, byte address, or character in `[7:0]`.
- `stall`  out  1  holds the pipeline; combinational.
- `mem_req`  out  1  byte read request.
- `mem_addr`  out  32  byte address.
- `mem_rdata`  in  8  read data, valid with `mem_ack`.
- `mem_ack`  in  1  read complete.
- `char_data`  out  8  ASCII byte.
- `char_valid`  out  1  byte offered.
- `char_ready`  in  1  sink accepts.
- `stat_control`  out  1  halt flag; sticky until reset.

## Operation
- Service codes:
  - 1: print signed integer.
  - 4: print string.
  - 10: exit.
  - 11: print character.
  - Any other code: no-op that completes through DONE.
- States: IDLE, INT_DIGIT, STR_REQ, STR_WAIT, EMIT, DONE, HALTED.
- IDLE, `syscall_control`=1: latch `v0` and `a0`, then dispatch.
  - code 1: if `a0`[31]=1, queue '-'. Magnitude = two's-complement negation as 32-bit unsigned, so -2147483648 gives 2147483648. Set k=9, then go to INT_DIGIT (via EMIT if '-' is queued).
  - code 4: ptr=`a0`, count=0, go to STR_REQ.
  - code 11: go to EMIT with `a0`[7:0].
  - code 10: set `stat_control`, go to HALTED.
  - other codes: go to DONE.
- INT_DIGIT: one compare/subtract per cycle.
  - If mag ≥ pow10[k]: mag -= pow10[k], digit++.
  - Otherwise the digit is final. Emit '0'+digit if digit≠0, or if a digit has already been emitted, or if k=0. Leading zeros are suppressed, so 0 prints "0".
  - After the digit is final: clear digit, decrement k. After k=0, go to DONE.
- STR_REQ: drive `mem_req`=1 with `mem_addr`=ptr, go to STR_WAIT.
- STR_WAIT: hold `mem_req` and `mem_addr` until `mem_ack`.
  - `mem_rdata`=0, or count=`MAX_STR_LEN`: go to DONE.
  - Otherwise: emit the byte, ptr++, count++, return to STR_REQ.
- EMIT: `char_valid`=1 with `char_data` held stable until `char_ready`, then return to the saved state. Zero-wait acceptance is allowed.
- DONE: one cycle with `stall`=0 so the pipeline retires the syscall, then go to IDLE. `syscall_control` high in IDLE on the following cycle is a new request.
- HALTED: terminal state; ignores all inputs; `stall`=1.
- `stall` = (`syscall_control` & state==IDLE & `v0`≠unknown) | (state∉{IDLE, DONE}). Unknown codes also stall for the single IDLE→DONE cycle; treat them as a known class "other".
  - Simplification: `stall` = `syscall_control` & state≠DONE, or state==HALTED.

## Timing
- Reset (async, immediate): state=IDLE; `stall` reflects only the inputs; `mem_req`=0, `mem_addr`=0, `char_valid`=0, `char_data`=0, `stat_control`=0. A reset mid-string or mid-digit abandons the operation and produces no further bytes.
- `mem_req`, `mem_addr`, `char_valid`, `char_data`, `stat_control` are registered.
- Print char latency: request cycle → `char_valid` next cycle → DONE the cycle after acceptance.
- String: each byte costs at least 3 cycles (REQ, WAIT with zero-wait ack, EMIT).
- Integer: at most 9 subtract cycles per digit plus 10 decision cycles plus emits.
- `mem_ack` asserted outside STR_WAIT is ignored.
- `char_ready` asserted while `char_valid`=0 is ignored.

## Structure
- Package `syscall_pkg`:
  - SYS_PRINT_INT=1, SYS_PRINT_STR=4, SYS_EXIT=10, SYS_PRINT_CHAR=11.
  - State enum.
  - pow10 table, 10×32-bit values 1…1,000,000,000.
- Sub-module `dec_digit_gen`: the magnitude/k/digit subtract loop with a digit-valid/digit-ready handshake to the parent FSM.

## Test plan
- `v0`=1, `a0`=0 → single byte '0'; `stall` low in DONE; exactly one `char_valid` handshake.
- `v0`=1, `a0`=32'h80000000 → bytes "-2147483648" (11 bytes) in order.
- `v0`=4, `a0`=0x100; memory holds 'H','i',0 → bytes 'H','i'; exactly 3 mem handshakes at addresses 0x100–0x102.
- `v0`=11, `a0`=0x41 with `char_ready` low for 5 cycles → `char_data`=0x41 stable for 5 cycles; `stall` stays 1 until acceptance plus DONE.
- `v0`=10 → `stat_control`=1 next cycle; `stall` stays 1 forever; later requests produce no output.
- String of 300 nonzero bytes with `MAX_STR_LEN`=256 → exactly 256 bytes; reset asserted mid-string → all outputs 0 immediately, no further bytes.
